// File: rtl/rtc_pkg.sv
// Shared definitions for the real-time clock preset and read paths.
// Holds the binary field widths, the time limits of each field, the BCD digit
// width, the reader state encoding and the field index constants.
// No ports (package).
package rtc_pkg;

    localparam int HH_W = 5;
    localparam int MM_W = 6;
    localparam int SS_W = 6;
    localparam int CS_W = 7;

    localparam int HH_MAX = 23;
    localparam int MM_MAX = 59;
    localparam int SS_MAX = 59;
    localparam int CS_MAX = 99;

    localparam int BCD_DIGIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_HOLD = 2'd2
    } rd_state_e;

    localparam logic [1:0] FLD_HH = 2'd0;
    localparam logic [1:0] FLD_MM = 2'd1;
    localparam logic [1:0] FLD_SS = 2'd2;
    localparam logic [1:0] FLD_CS = 2'd3;

endpackage

// File: rtl/rtc_time_reader_if.sv
// Request / result bundle of the RTC time reader.
//   req, hours, minutes, seconds, centis : snapshot request and counter values
//   busy                                 : conversion in progress
//   valid, ready                         : result handshake
//   bcd_time, range_err                  : packed {HH,MM,SS,CS} BCD result + qualifier
// master = requester/consumer side, slave = the reader.
interface rtc_time_reader_if;
    import rtc_pkg::*;

    logic            req;
    logic [HH_W-1:0] hours;
    logic [MM_W-1:0] minutes;
    logic [SS_W-1:0] seconds;
    logic [CS_W-1:0] centis;
    logic            busy;
    logic            valid;
    logic            ready;
    logic [31:0]     bcd_time;
    logic            range_err;

    modport master (
        output req, hours, minutes, seconds, centis, ready,
        input  busy, valid, bcd_time, range_err
    );

    modport slave (
        input  req, hours, minutes, seconds, centis, ready,
        output busy, valid, bcd_time, range_err
    );

endinterface

// File: rtl/dd_step.sv
// One double-dabble iteration for a two-digit BCD pair.
// Ports:
//   bcd_i : current BCD pair {tens, ones}
//   bin_i : remaining binary bits, MSB shifts into the BCD pair
//   bcd_o : add-3-adjusted, left-shifted BCD pair
//   bin_o : binary value shifted left by one
module dd_step
    import rtc_pkg::*;
#(
    parameter int BIN_W = 7
) (
    input  logic [7:0]       bcd_i,
    input  logic [BIN_W-1:0] bin_i,
    output logic [7:0]       bcd_o,
    output logic [BIN_W-1:0] bin_o
);

    logic [BCD_DIGIT_W-1:0] lo_adj;
    logic [BCD_DIGIT_W-1:0] hi_adj;
    logic [BIN_W+7:0]       shifted;

    always_comb begin
        lo_adj = (bcd_i[3:0] >= 4'd5) ? bcd_i[3:0] + 4'd3 : bcd_i[3:0];
        hi_adj = (bcd_i[7:4] >= 4'd5) ? bcd_i[7:4] + 4'd3 : bcd_i[7:4];
        // Inputs never exceed 99, so the bit shifted out of the tens digit is always 0.
        shifted = {hi_adj, lo_adj, bin_i} << 1;
        bcd_o   = shifted[BIN_W+7:BIN_W];
        bin_o   = shifted[BIN_W-1:0];
    end

endmodule

// File: rtl/rtc_time_reader.sv
// Snapshot the binary HH/MM/SS/CS counters on request and convert each field
// serially (HH, MM, SS, CS) to two BCD digits, one double-dabble step per clock.
// The result is offered on a valid/ready handshake 28 cycles after acceptance.
// Ports:
//   CLOCK_50 : system clock, rising edge
//   Clrn     : synchronous active-low reset
//   bus      : rtc_time_reader_if.slave (req, counters, busy, valid/ready, result)
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for req; accepts and snapshots the counters
// CONV    | 7 shift-add-3 steps per field, fields back to back
// HOLD    | result valid, held until ready
module rtc_time_reader
    import rtc_pkg::*;
#(
    parameter int BIN_W     = 7,
    parameter int CLAMP_VAL = 99
) (
    input  logic              CLOCK_50,
    input  logic              Clrn,
    rtc_time_reader_if.slave  bus
);

    localparam logic [2:0] ITER_LAST = 3'(BIN_W - 1);

    rd_state_e        state_q, state_d;
    logic [1:0]       field_q, field_d;
    logic [2:0]       iter_q, iter_d;
    logic [7:0]       bcd_q, bcd_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [BIN_W-1:0] snap_mm_q, snap_mm_d;
    logic [BIN_W-1:0] snap_ss_q, snap_ss_d;
    logic [BIN_W-1:0] snap_cs_q, snap_cs_d;
    logic             err_snap_q, err_snap_d;
    logic [23:0]      res_q, res_d;
    logic [31:0]      bcd_time_q, bcd_time_d;
    logic             range_err_q, range_err_d;

    logic [7:0]       step_bcd;
    logic [BIN_W-1:0] step_bin;
    logic             accept;
    logic             iter_tc;
    logic             field_done;
    logic             conv_done;
    logic             busy_o;
    logic             valid_o;

    function automatic logic [BIN_W-1:0] clamp_f(input logic [BIN_W-1:0] v);
        return (int'(v) > 99) ? BIN_W'(CLAMP_VAL) : v;
    endfunction

    dd_step #(.BIN_W(BIN_W)) u_dd_step (
        .bcd_i (bcd_q),
        .bin_i (bin_q),
        .bcd_o (step_bcd),
        .bin_o (step_bin)
    );

    assign accept     = (state_q == ST_IDLE) && bus.req;
    assign iter_tc    = (iter_q == 3'd0);
    assign field_done = (state_q == ST_CONV) && iter_tc;
    assign conv_done  = field_done && (field_q == FLD_CS);

    // State register
    always_ff @(posedge CLOCK_50) begin
        if (!Clrn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (bus.req)   state_d = ST_CONV;
            ST_CONV: if (conv_done) state_d = ST_HOLD;
            ST_HOLD: if (bus.ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy_o  = (state_q == ST_CONV);
        valid_o = (state_q == ST_HOLD);
    end

    assign bus.busy      = busy_o;
    assign bus.valid     = valid_o;
    assign bus.bcd_time  = bcd_time_q;
    assign bus.range_err = range_err_q;

    // Datapath next values
    always_comb begin
        field_d     = field_q;
        iter_d      = iter_q;
        bcd_d       = bcd_q;
        bin_d       = bin_q;
        snap_mm_d   = snap_mm_q;
        snap_ss_d   = snap_ss_q;
        snap_cs_d   = snap_cs_q;
        err_snap_d  = err_snap_q;
        res_d       = res_q;
        bcd_time_d  = bcd_time_q;
        range_err_d = range_err_q;

        if (accept) begin
            bin_d      = clamp_f(BIN_W'(bus.hours));
            snap_mm_d  = clamp_f(BIN_W'(bus.minutes));
            snap_ss_d  = clamp_f(BIN_W'(bus.seconds));
            snap_cs_d  = clamp_f(BIN_W'(bus.centis));
            err_snap_d = (int'(bus.hours)   > HH_MAX) || (int'(bus.minutes) > MM_MAX) ||
                         (int'(bus.seconds) > SS_MAX) || (int'(bus.centis)  > CS_MAX);
            bcd_d      = '0;
            iter_d     = ITER_LAST;
            field_d    = FLD_HH;
        end else if (state_q == ST_CONV) begin
            if (field_done) begin
                // Last step of this field: store its byte and load the next field
                // on the same edge so fields run back to back.
                unique case (field_q)
                    FLD_HH:  res_d[23:16] = step_bcd;
                    FLD_MM:  res_d[15:8]  = step_bcd;
                    FLD_SS:  res_d[7:0]   = step_bcd;
                    default: res_d        = res_q;
                endcase
                unique case (field_q)
                    FLD_HH:  bin_d = snap_mm_q;
                    FLD_MM:  bin_d = snap_ss_q;
                    FLD_SS:  bin_d = snap_cs_q;
                    default: bin_d = '0;
                endcase
                bcd_d   = '0;
                iter_d  = ITER_LAST;
                field_d = field_q + 2'd1;
                if (conv_done) begin
                    bcd_time_d  = {res_q, step_bcd};
                    range_err_d = err_snap_q;
                end
            end else begin
                bcd_d  = step_bcd;
                bin_d  = step_bin;
                iter_d = iter_q - 3'd1;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!Clrn) begin
            field_q     <= '0;
            iter_q      <= '0;
            bcd_q       <= '0;
            bin_q       <= '0;
            snap_mm_q   <= '0;
            snap_ss_q   <= '0;
            snap_cs_q   <= '0;
            err_snap_q  <= 1'b0;
            res_q       <= '0;
            bcd_time_q  <= '0;
            range_err_q <= 1'b0;
        end else begin
            field_q     <= field_d;
            iter_q      <= iter_d;
            bcd_q       <= bcd_d;
            bin_q       <= bin_d;
            snap_mm_q   <= snap_mm_d;
            snap_ss_q   <= snap_ss_d;
            snap_cs_q   <= snap_cs_d;
            err_snap_q  <= err_snap_d;
            res_q       <= res_d;
            bcd_time_q  <= bcd_time_d;
            range_err_q <= range_err_d;
        end
    end

endmodule

// File: tb/tb_rtc_time_reader.sv
// Scoreboard bench for rtc_time_reader: stimulus pushes the hand-computed
// result, a negedge monitor pops and checks it when valid rises, checks the
// 28-cycle latency and the result stability while valid is held.
module tb_rtc_time_reader;
    import rtc_pkg::*;

    typedef struct {
        logic [31:0] bcd;
        logic        err;
    } exp_t;

    logic CLOCK_50 = 1'b0;
    logic Clrn     = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    rtc_time_reader_if bus();

    rtc_time_reader dut (
        .CLOCK_50 (CLOCK_50),
        .Clrn     (Clrn),
        .bus      (bus)
    );

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   start_cyc = 0;
    int   rise_cyc  = 0;
    int   fall_cyc  = 0;
    logic busy_p  = 1'b0;
    logic valid_p = 1'b0;
    exp_t cur;
    exp_t exp_q[$];

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor
    always @(negedge CLOCK_50) begin
        if (bus.busy && !busy_p) begin
            start_cyc = cyc;
            rise_cyc  = cyc;
        end
        if (!bus.valid && valid_p) fall_cyc = cyc;
        if (bus.valid && !valid_p) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got bcd %h with no expected entry", bus.bcd_time);
            end else begin
                cur = exp_q.pop_front();
                chk("bcd_time", bus.bcd_time, cur.bcd);
                chk("range_err", 32'(bus.range_err), 32'(cur.err));
                chk("latency", 32'(cyc - start_cyc), 32'd28);
                chk("busy_at_valid", 32'(bus.busy), 32'd0);
            end
        end else if (bus.valid && valid_p) begin
            chk("hold_bcd_stable", bus.bcd_time, cur.bcd);
            chk("hold_err_stable", 32'(bus.range_err), 32'(cur.err));
        end
        busy_p  = bus.busy;
        valid_p = bus.valid;
    end

    task automatic start_req(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s,
                             input logic [6:0] c, input logic [31:0] eb, input logic ee);
        exp_t e;
        e.bcd = eb;
        e.err = ee;
        bus.hours   = h;
        bus.minutes = m;
        bus.seconds = s;
        bus.centis  = c;
        exp_q.push_back(e);
        bus.req = 1'b1;
        @(negedge CLOCK_50);
        bus.req = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!bus.valid && n < 40) begin
            @(negedge CLOCK_50);
            n++;
        end
        if (!bus.valid) begin
            total++;
            bad++;
            $display("FAIL %s: valid timeout got 0 expected 1", name);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.req     = 1'b0;
        bus.ready   = 1'b0;
        bus.hours   = '0;
        bus.minutes = '0;
        bus.seconds = '0;
        bus.centis  = '0;

        // Reset state
        Clrn = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_valid", 32'(bus.valid), 32'd0);
        chk("rst_bcd", bus.bcd_time, 32'd0);
        chk("rst_err", 32'(bus.range_err), 32'd0);
        Clrn = 1'b1;
        @(negedge CLOCK_50);

        // 1: maximum legal time, held result until ready
        start_req(5'd23, 6'd59, 6'd59, 7'd99, 32'h23595999, 1'b0);
        wait_valid("t1");
        repeat (3) @(negedge CLOCK_50);
        bus.ready = 1'b1;
        @(negedge CLOCK_50);
        chk("t1_valid_drop", 32'(bus.valid), 32'd0);
        bus.ready = 1'b0;

        // 2: all zero, ready tied high -> valid for exactly one cycle
        bus.ready = 1'b1;
        start_req(5'd0, 6'd0, 6'd0, 7'd0, 32'h00000000, 1'b0);
        wait_valid("t2");
        @(negedge CLOCK_50);
        chk("t2_valid_one_cycle", 32'(bus.valid), 32'd0);
        chk("t2_idle_not_busy", 32'(bus.busy), 32'd0);
        bus.ready = 1'b0;
        @(negedge CLOCK_50);

        // 3: out-of-range fields, CS clamped to 99
        start_req(5'd31, 6'd63, 6'd60, 7'd127, 32'h31636099, 1'b1);
        wait_valid("t3");
        bus.ready = 1'b1;
        @(negedge CLOCK_50);
        bus.ready = 1'b0;

        // 4: inputs scrambled after acceptance, ready held low 10 cycles
        start_req(5'd12, 6'd34, 6'd56, 7'd78, 32'h12345678, 1'b0);
        n = 0;
        while (!bus.valid && n < 40) begin
            bus.hours   = 5'($urandom);
            bus.minutes = 6'($urandom);
            bus.seconds = 6'($urandom);
            bus.centis  = 7'($urandom);
            @(negedge CLOCK_50);
            n++;
        end
        wait_valid("t4");
        repeat (10) @(negedge CLOCK_50);
        chk("t4_valid_held", 32'(bus.valid), 32'd1);
        bus.ready = 1'b1;
        @(negedge CLOCK_50);
        chk("t4_valid_drop", 32'(bus.valid), 32'd0);
        chk("t4_bcd_kept", bus.bcd_time, 32'h12345678);
        bus.ready = 1'b0;
        @(negedge CLOCK_50);

        // 5: req held high -> one conversion per IDLE visit, re-accept right after HOLD exit
        bus.hours   = 5'd1;
        bus.minutes = 6'd2;
        bus.seconds = 6'd3;
        bus.centis  = 7'd4;
        exp_q.push_back('{32'h01020304, 1'b0});
        exp_q.push_back('{32'h01020304, 1'b0});
        bus.ready = 1'b1;
        bus.req   = 1'b1;
        @(negedge CLOCK_50);
        wait_valid("t5a");
        @(negedge CLOCK_50);
        wait_valid("t5b");
        bus.req = 1'b0;
        chk("t5_reaccept_gap", 32'(rise_cyc - fall_cyc), 32'd1);
        @(negedge CLOCK_50);
        chk("t5_back_idle", 32'(bus.valid | bus.busy), 32'd0);
        bus.ready = 1'b0;

        // 6: reset mid-conversion, then a normal conversion
        start_req(5'd5, 6'd6, 6'd7, 7'd8, 32'h05060708, 1'b0);
        repeat (9) @(negedge CLOCK_50);
        Clrn = 1'b0;
        @(negedge CLOCK_50);
        chk("t6_rst_busy", 32'(bus.busy), 32'd0);
        chk("t6_rst_valid", 32'(bus.valid), 32'd0);
        chk("t6_rst_bcd", bus.bcd_time, 32'd0);
        chk("t6_rst_err", 32'(bus.range_err), 32'd0);
        exp_q.delete();
        Clrn = 1'b1;
        @(negedge CLOCK_50);
        start_req(5'd9, 6'd10, 6'd11, 7'd12, 32'h09101112, 1'b0);
        wait_valid("t6");
        bus.ready = 1'b1;
        @(negedge CLOCK_50);
        bus.ready = 1'b0;

        repeat (3) @(negedge CLOCK_50);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
